// File: rtl/ftdi_pkg.sv
// Shared definitions for the FT2232H synchronous 245 FIFO receive and transmit paths.
package ftdi_pkg;

    // Bus-side FSM states, common to the receive and transmit blocks
    typedef enum logic [2:0] {
        FTDI_IDLE,
        FTDI_REQ,
        FTDI_OE,
        FTDI_READ,
        FTDI_STOP
    } ftdiState_t;

    // Cycles of OE_n low before the first RD_n strobe (bus turnaround)
    localparam int unsigned cTurnaround = 1;

    // Bus-owner encoding used by the top-level arbiter
    typedef enum logic [1:0] {
        BUS_NONE,
        BUS_RX,
        BUS_TX
    } busOwner_t;

endpackage

// File: rtl/ftdi_rx_level.sv
// Receive buffer occupancy and complete-packet counter.
module ftdi_rx_level #(
    parameter int unsigned pDepth     = 16,
    parameter int unsigned pPacketLen = 4
) (
    input  logic                      iClk,
    input  logic                      iRst_n,
    input  logic                      iCapture,
    input  logic                      iPacketWrap,
    input  logic                      iPacketRead,
    output logic [$clog2(pDepth):0]   oLevel,
    output logic                      oPacketAvail,
    output logic                      oFull,
    output logic                      oFillNow
);

    localparam int unsigned cLvlW = $clog2(pDepth) + 1;

    logic [cLvlW-1:0] pktCnt;
    logic [cLvlW-1:0] levelNext;
    logic             relPkt;

    // A release request with no complete packet buffered is ignored
    assign relPkt = iPacketRead && (pktCnt != '0);

    // Next occupancy: one byte in per capture, one packet out per accepted release
    always_comb begin
        levelNext = oLevel;
        if (iCapture) begin
            levelNext = levelNext + cLvlW'(1);
        end
        if (relPkt) begin
            levelNext = levelNext - cLvlW'(pPacketLen);
        end
    end

    assign oFull        = (oLevel == cLvlW'(pDepth));
    assign oFillNow     = iCapture && (levelNext == cLvlW'(pDepth));
    assign oPacketAvail = (pktCnt != '0);

    // Occupancy and packet count registers; completion and release on one edge cancel
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oLevel <= '0;
            pktCnt <= '0;
        end else begin
            oLevel <= levelNext;
            case ({iPacketWrap, relPkt})
                2'b10:   pktCnt <= pktCnt + cLvlW'(1);
                2'b01:   pktCnt <= pktCnt - cLvlW'(1);
                default: pktCnt <= pktCnt;
            endcase
        end
    end

endmodule

// File: rtl/ftdi_input.sv
// Host-to-FPGA receive path: drains the FTDI RX FIFO into a circular RAM buffer.
module ftdi_input
    import ftdi_pkg::*;
#(
    parameter int unsigned pDataWidth = 8,
    parameter int unsigned pDepth     = 16,
    parameter int unsigned pPacketLen = 4
) (
    input  logic                        iClk,
    input  logic                        iRst_n,
    input  logic [pDataWidth-1:0]       iFifoData,
    input  logic                        iRxF_n,
    output logic                        oRd_n,
    output logic                        oOe_n,
    output logic                        oBusReq,
    input  logic                        iBusGnt,
    output logic                        oRamWrEn,
    output logic [$clog2(pDepth)-1:0]   oRamWrAddr,
    output logic [pDataWidth-1:0]       oRamWrData,
    output logic                        oPacketAvail,
    input  logic                        iPacketRead,
    output logic [$clog2(pDepth):0]     oLevel
);

    localparam int unsigned cAddrW = $clog2(pDepth);
    localparam int unsigned cByteW = (pPacketLen > 1) ? $clog2(pPacketLen) : 1;

    ftdiState_t        state;
    logic              rxfQ;
    logic [1:0]        taCnt;
    logic [cAddrW-1:0] wrPtr;
    logic [cByteW-1:0] byteCnt;
    logic              capture;
    logic              pktWrap;
    logic              full;
    logic              fillNow;

    assign capture = (state == FTDI_READ) && !iRxF_n && !oRd_n;
    assign pktWrap = capture && (byteCnt == cByteW'(pPacketLen - 1));

    // Registered RX-FIFO flag used to start a burst; READ watches the raw pin
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rxfQ <= 1'b1;
        end else begin
            rxfQ <= iRxF_n;
        end
    end

    // Bus FSM with registered FTDI strobes and bus request
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state   <= FTDI_IDLE;
            oBusReq <= 1'b0;
            oOe_n   <= 1'b1;
            oRd_n   <= 1'b1;
            taCnt   <= '0;
        end else begin
            case (state)
                FTDI_IDLE: begin
                    if (!rxfQ && !full) begin
                        state   <= FTDI_REQ;
                        oBusReq <= 1'b1;
                    end
                end
                FTDI_REQ: begin
                    if (iBusGnt) begin
                        state <= FTDI_OE;
                        oOe_n <= 1'b0;
                        taCnt <= '0;
                    end
                end
                FTDI_OE: begin
                    if (taCnt == 2'(cTurnaround - 1)) begin
                        state <= FTDI_READ;
                        oRd_n <= 1'b0;
                    end else begin
                        taCnt <= taCnt + 2'd1;
                    end
                end
                FTDI_READ: begin
                    if (iRxF_n || fillNow) begin
                        state <= FTDI_STOP;
                        oRd_n <= 1'b1;
                        oOe_n <= 1'b1;
                    end
                end
                default: begin
                    state   <= FTDI_IDLE;
                    oBusReq <= 1'b0;
                end
            endcase
        end
    end

    // Write pointer and byte-in-packet counter advance once per captured byte
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wrPtr   <= '0;
            byteCnt <= '0;
        end else if (capture) begin
            wrPtr   <= (wrPtr == cAddrW'(pDepth - 1)) ? '0 : wrPtr + cAddrW'(1);
            byteCnt <= pktWrap ? '0 : byteCnt + cByteW'(1);
        end
    end

    // Registered RAM write port, valid the cycle after the capture edge
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oRamWrEn   <= 1'b0;
            oRamWrAddr <= '0;
            oRamWrData <= '0;
        end else begin
            oRamWrEn <= capture;
            if (capture) begin
                oRamWrAddr <= wrPtr;
                oRamWrData <= iFifoData;
            end
        end
    end

    ftdi_rx_level #(
        .pDepth     (pDepth),
        .pPacketLen (pPacketLen)
    ) uLevel (
        .iClk         (iClk),
        .iRst_n       (iRst_n),
        .iCapture     (capture),
        .iPacketWrap  (pktWrap),
        .iPacketRead  (iPacketRead),
        .oLevel       (oLevel),
        .oPacketAvail (oPacketAvail),
        .oFull        (full),
        .oFillNow     (fillNow)
    );

endmodule

// File: tb/tb_ftdi_input.sv
// Scoreboard bench for ftdi_input: host FIFO model, RAM-write monitor, directed scenarios.
module tb_ftdi_input;

    logic       iClk = 1'b0;
    logic       iRst_n = 1'b0;
    logic [7:0] iFifoData = 8'h00;
    logic       iRxF_n = 1'b1;
    logic       oRd_n;
    logic       oOe_n;
    logic       oBusReq;
    logic       iBusGnt = 1'b1;
    logic       oRamWrEn;
    logic [3:0] oRamWrAddr;
    logic [7:0] oRamWrData;
    logic       oPacketAvail;
    logic       iPacketRead = 1'b0;
    logic [4:0] oLevel;

    int nChecks = 0;
    int nFails  = 0;
    int nWrites = 0;
    int wrMark  = 0;

    logic [7:0]  hostQ[$];
    logic [11:0] expQ[$];
    logic [3:0]  expAddr = 4'd0;
    logic [11:0] monE;
    logic        popNow;

    ftdi_input #(
        .pDataWidth (8),
        .pDepth     (16),
        .pPacketLen (4)
    ) dut (
        .iClk         (iClk),
        .iRst_n       (iRst_n),
        .iFifoData    (iFifoData),
        .iRxF_n       (iRxF_n),
        .oRd_n        (oRd_n),
        .oOe_n        (oOe_n),
        .oBusReq      (oBusReq),
        .iBusGnt      (iBusGnt),
        .oRamWrEn     (oRamWrEn),
        .oRamWrAddr   (oRamWrAddr),
        .oRamWrData   (oRamWrData),
        .oPacketAvail (oPacketAvail),
        .iPacketRead  (iPacketRead),
        .oLevel       (oLevel)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Host-side FIFO pins reflect the head of the host queue
    task automatic driveBus();
        iRxF_n    = (hostQ.size() == 0);
        iFifoData = (hostQ.size() != 0) ? hostQ[0] : 8'h00;
    endtask

    task automatic pushBytes(input logic [7:0] base, input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i);
            hostQ.push_back(b);
            expQ.push_back({expAddr, b});
            expAddr = expAddr + 4'd1;
        end
        driveBus();
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic waitBusReq(input logic val, input int maxCyc, input string name);
        int n = 0;
        while (oBusReq !== val && n < maxCyc) begin
            cycle(1);
            n++;
        end
        check(name, 32'(oBusReq), 32'(val));
    endtask

    task automatic pktRead();
        @(negedge iClk);
        iPacketRead = 1'b1;
        @(posedge iClk);
        #1;
        iPacketRead = 1'b0;
    endtask

    task automatic doReset();
        @(negedge iClk);
        #2;
        iRst_n = 1'b0;
        #1;
        check("rstRd",      32'(oRd_n), 32'd1);
        check("rstOe",      32'(oOe_n), 32'd1);
        check("rstReq",     32'(oBusReq), 32'd0);
        check("rstWrEn",    32'(oRamWrEn), 32'd0);
        check("rstWrAddr",  32'(oRamWrAddr), 32'd0);
        check("rstWrData",  32'(oRamWrData), 32'd0);
        check("rstAvail",   32'(oPacketAvail), 32'd0);
        check("rstLevel",   32'(oLevel), 32'd0);
        hostQ.delete();
        expQ.delete();
        expAddr     = 4'd0;
        iPacketRead = 1'b0;
        iBusGnt     = 1'b1;
        driveBus();
        @(negedge iClk);
        iRst_n = 1'b1;
        cycle(2);
    endtask

    // FTDI FIFO: a byte leaves the host queue on each edge the DUT strobes RD_n with data present
    always @(posedge iClk) begin
        popNow = iRst_n && !oRd_n && !iRxF_n;
        #1;
        if (popNow && hostQ.size() != 0) begin
            void'(hostQ.pop_front());
        end
        driveBus();
    end

    // Monitor: every RAM write must match the next expected {addr, data}
    always @(negedge iClk) begin
        if (iRst_n && oRamWrEn) begin
            nWrites++;
            if (expQ.size() == 0) begin
                check("writeExpected", 32'(expQ.size()), 32'd1);
            end else begin
                monE = expQ.pop_front();
                check("wrAddr", 32'(oRamWrAddr), 32'(monE[11:8]));
                check("wrData", 32'(oRamWrData), 32'(monE[7:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        doReset();

        // Single packet with strobe latencies
        @(negedge iClk);
        pushBytes(8'hA1, 4);
        cycle(1);
        check("lat0Req", 32'(oBusReq), 32'd0);
        cycle(1);
        check("lat1Req", 32'(oBusReq), 32'd1);
        check("lat1Oe",  32'(oOe_n), 32'd1);
        cycle(1);
        check("lat2Oe",  32'(oOe_n), 32'd0);
        check("lat2Rd",  32'(oRd_n), 32'd1);
        cycle(1);
        check("lat3Rd",  32'(oRd_n), 32'd0);
        check("lat3WrEn", 32'(oRamWrEn), 32'd0);
        cycle(1);
        check("lat4WrEn", 32'(oRamWrEn), 32'd1);
        cycle(2);
        check("pkt1Lvl3", 32'(oLevel), 32'd3);
        check("pkt1Avail0", 32'(oPacketAvail), 32'd0);
        cycle(1);
        check("pkt1WrEn", 32'(oRamWrEn), 32'd1);
        check("pkt1Lvl4", 32'(oLevel), 32'd4);
        check("pkt1Avail", 32'(oPacketAvail), 32'd1);
        waitBusReq(1'b0, 10, "pkt1Release");
        pktRead();
        check("pkt1RdLvl", 32'(oLevel), 32'd0);
        check("pkt1RdAvail", 32'(oPacketAvail), 32'd0);

        // Early stop, then completion of the packet
        doReset();
        @(negedge iClk);
        pushBytes(8'hB0, 2);
        waitBusReq(1'b1, 10, "earlyReq");
        waitBusReq(1'b0, 20, "earlyRelease");
        check("earlyLvl", 32'(oLevel), 32'd2);
        check("earlyAvail", 32'(oPacketAvail), 32'd0);
        @(negedge iClk);
        pushBytes(8'hB2, 2);
        waitBusReq(1'b1, 10, "early2Req");
        waitBusReq(1'b0, 20, "early2Release");
        check("early2Lvl", 32'(oLevel), 32'd4);
        check("early2Avail", 32'(oPacketAvail), 32'd1);

        // Release on the same edge a second packet completes
        doReset();
        @(negedge iClk);
        pushBytes(8'hC0, 4);
        waitBusReq(1'b1, 10, "simReq");
        waitBusReq(1'b0, 20, "simRelease");
        check("simLvl4", 32'(oLevel), 32'd4);
        @(negedge iClk);
        pushBytes(8'hC4, 4);
        repeat (7) @(posedge iClk);
        @(negedge iClk);
        iPacketRead = 1'b1;
        @(posedge iClk);
        #1;
        iPacketRead = 1'b0;
        check("simWrEn", 32'(oRamWrEn), 32'd1);
        check("simLvl", 32'(oLevel), 32'd4);
        check("simAvail", 32'(oPacketAvail), 32'd1);
        waitBusReq(1'b0, 20, "simRelease2");
        pktRead();
        check("simDrainLvl", 32'(oLevel), 32'd0);
        check("simDrainAvail", 32'(oPacketAvail), 32'd0);
        pktRead();
        check("emptyRdLvl", 32'(oLevel), 32'd0);
        check("emptyRdAvail", 32'(oPacketAvail), 32'd0);

        // Buffer full with host data still pending
        doReset();
        wrMark = nWrites;
        @(negedge iClk);
        pushBytes(8'hD0, 20);
        waitBusReq(1'b1, 10, "fullReq");
        waitBusReq(1'b0, 60, "fullRelease");
        check("fullWrites", 32'(nWrites - wrMark), 32'd16);
        check("fullLvl", 32'(oLevel), 32'd16);
        check("fullAvail", 32'(oPacketAvail), 32'd1);
        check("fullRd", 32'(oRd_n), 32'd1);
        check("fullHostPending", 32'(iRxF_n), 32'd0);
        cycle(5);
        check("fullIdleReq", 32'(oBusReq), 32'd0);
        check("fullIdleWrites", 32'(nWrites - wrMark), 32'd16);
        pktRead();
        check("fullRdLvl", 32'(oLevel), 32'd12);
        waitBusReq(1'b1, 10, "resumeReq");
        waitBusReq(1'b0, 30, "resumeRelease");
        check("resumeWrites", 32'(nWrites - wrMark), 32'd20);
        check("resumeLvl", 32'(oLevel), 32'd16);
        check("resumeDrained", 32'(expQ.size()), 32'd0);

        // Grant withheld for five cycles
        doReset();
        wrMark = nWrites;
        @(negedge iClk);
        iBusGnt = 1'b0;
        pushBytes(8'hE0, 4);
        cycle(2);
        for (int i = 0; i < 5; i++) begin
            cycle(1);
            check("gntReq", 32'(oBusReq), 32'd1);
            check("gntOe", 32'(oOe_n), 32'd1);
            check("gntRd", 32'(oRd_n), 32'd1);
            check("gntNoWrite", 32'(nWrites - wrMark), 32'd0);
        end
        @(negedge iClk);
        iBusGnt = 1'b1;
        cycle(1);
        check("gntOeLow", 32'(oOe_n), 32'd0);
        cycle(1);
        check("gntRdLow", 32'(oRd_n), 32'd0);
        waitBusReq(1'b0, 20, "gntRelease");
        check("gntLvl", 32'(oLevel), 32'd4);
        check("gntAvail", 32'(oPacketAvail), 32'd1);

        // Reset in the middle of a burst
        doReset();
        @(negedge iClk);
        pushBytes(8'hF0, 8);
        cycle(6);
        check("midBurstRd", 32'(oRd_n), 32'd0);
        check("midBurstLvl", 32'(oLevel), 32'd2);
        doReset();
        cycle(5);
        check("postRstReq", 32'(oBusReq), 32'd0);
        check("postRstLvl", 32'(oLevel), 32'd0);
        check("finalDrained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ftdi_input.md
# ftdi_input

Host-to-FPGA receive path for the FT2232H synchronous 245 FIFO; the counterpart of the FPGA-to-host transmit block on the same 60 MHz FTDI bus. Pulls bytes from the FTDI RX FIFO whenever data is present and local space exists, then writes them into a circular RAM buffer. Counts complete fixed-length packets for a downstream command consumer. Shares the FTDI data bus with the transmit block through a request/grant handshake to the top-level arbiter.

## Interface
- pDataWidth, 8, byte width of FTDI bus and RAM word
- pDepth, 16, RAM depth in bytes; power of 2, integer multiple of pPacketLen
- pPacketLen, 4, bytes per packet
- iClk  in  1  60 MHz FTDI CLKOUT; sole clock
- iRst_n  in  1  reset, asynchronous, active-low
- iFifoData  in  pDataWidth  FTDI data bus, input side (top level owns the tristate)
- iRxF_n  in  1  FTDI RX FIFO has data (low)
- oRd_n  out  1  FTDI read strobe (low = transfer)
- oOe_n  out  1  FTDI output enable (low = FTDI drives bus)
- oBusReq  out  1  request ownership of FTDI bus
- iBusGnt  in  1  arbiter grant; held high until oBusReq drops
- oRamWrEn  out  1  RAM write strobe
- oRamWrAddr  out  $clog2(pDepth)  RAM write address
- oRamWrData  out  pDataWidth  RAM write data
- oPacketAvail  out  1  at least one complete packet buffered
- iPacketRead  in  1  one-cycle pulse: consumer has released the oldest packet
- oLevel  out  $clog2(pDepth)+1  bytes held in buffer, partial packet included

## Operation
- FSM states: IDLE, REQ, OE, READ, STOP.
- IDLE -> REQ when iRxF_n=0 and oLevel<pDepth. oBusReq is set to 1.
- REQ -> OE when iBusGnt=1. oOe_n is set to 0. Provides one bus-turnaround cycle.
- OE -> READ. oRd_n is set to 0.
- READ: each edge with iRxF_n=0 and oRd_n=0 captures iFifoData as one byte.
- READ -> STOP on either condition:
  - iRxF_n=1: no byte is captured on that edge.
  - The capture on this edge makes the level reach pDepth.
- On the READ -> STOP edge, oRd_n and oOe_n go to 1.
- STOP -> IDLE. oBusReq is set to 0.
- Capture writes RAM at the write pointer. The write pointer increments and wraps pDepth-1 -> 0.
- Byte-in-packet counter increments per capture and wraps at pPacketLen-1 -> 0. On wrap, the packet count increments.
- oPacketAvail = (packet count != 0).
- iPacketRead with packet count>0: packet count -1, level -pPacketLen. iPacketRead with packet count=0 is ignored.
- Same-edge packet completion and iPacketRead: packet count unchanged; level = level +1 -pPacketLen.
- Level never exceeds pDepth, and no RAM location is written while unreleased.

## Timing
- Reset (async, immediate):
  - oRd_n=1, oOe_n=1, oBusReq=0, oRamWrEn=0.
  - oRamWrAddr=0, oRamWrData=0, oPacketAvail=0, oLevel=0.
  - FSM in IDLE; all counters 0.
- Reset mid-burst: the FTDI strobes are released at once and any partial packet is discarded.
- Latencies from iRxF_n falling, sampled at edge 0 with grant already high:
  - oBusReq=1 after edge 1.
  - oOe_n=0 after edge 2.
  - oRd_n=0 after edge 3.
  - First byte captured at edge 4.
- RAM write is registered: oRamWrEn/Addr/Data are valid for the one cycle after the capture edge.
- oPacketAvail and oLevel update on the same edge as the completing RAM write, i.e. one cycle after capture.
- Sustained throughput is 1 byte/cycle while iRxF_n=0 and space remains.
- Minimum re-entry after STOP: 1 cycle in IDLE.

## Structure
- Shared package ftdi_pkg:
  - FSM state encodings (shared with the transmit block).
  - FTDI turnaround constant (1 cycle OE-before-RD).
  - Bus-owner encoding used by the arbiter.
- One sub-module, ftdi_rx_level: occupancy and packet counter.
  - Inputs: capture, packet-wrap and iPacketRead.
  - Outputs: oLevel, oPacketAvail and the full flag.
- FSM, pointers and RAM write register stay in ftdi_input.

## Test plan
All scenarios use pDepth=16, pPacketLen=4.
- Reset: drive iRst_n low mid-burst with iRxF_n=0 -> oRd_n=1, oOe_n=1, oBusReq=0 immediately; oLevel=0.
- Single packet: send bytes 0xA1..0xA4, grant immediate.
  - oBusReq, oOe_n, oRd_n follow at +1/+2/+3 cycles.
  - RAM writes addr 0..3 with 0xA1..0xA4.
  - oPacketAvail=1 and oLevel=4 with the last write.
- Full: host sends 20 bytes with no iPacketRead.
  - Exactly 16 writes, then oRd_n=1 and FSM idles with iRxF_n still 0.
  - One iPacketRead -> oLevel=12, transfer resumes, byte 17 written at addr 0.
- Early stop:
  - iRxF_n rises after 2 bytes -> STOP, oLevel=2, oPacketAvail=0.
  - 2 more bytes later -> packet count 1 at addrs 2..3.
- Simultaneous: iPacketRead on the cycle a 2nd packet completes -> packet count stays 1, oLevel 4 (8 -4).
- Grant delay: hold iBusGnt low 5 cycles -> oBusReq stays high, oOe_n and oRd_n stay 1, no capture until grant.
